// File: rtl/ula_pipe_param.sv
// ula_pipe_param: pipelined MIC ALU with output shifter, N/Z flags, a flag
// register and a valid/ready elastic pipeline of 1 or 2 register stages.
module ula_pipe_param #(
  parameter int WIDTH = 32,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       ctrl,
  input  logic [1:0]       shift,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             N,
  output logic             Z,
  output logic             shift_err,
  output logic [1:0]       nz_q
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cy;
    logic             n;
    logic             z;
    logic             err;
  } res_t;

  // ctrl = {F0,F1,ENA,ENB,INVA,INC}, shift = {SLL8,SRA1}
  function automatic res_t alu(input logic [5:0]       c,
                               input logic [1:0]       s,
                               input logic [WIDTH-1:0] a_in,
                               input logic [WIDTH-1:0] b_in);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
    logic [WIDTH:0]   sum;
    res_t             o;
    o   = '0;
    a   = (c[3] ? a_in : '0) ^ {WIDTH{c[1]}};
    b   = c[2] ? b_in : '0;
    sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c[0]};
    case (c[5:4])
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~b;
      default: begin
        r    = sum[WIDTH-1:0];
        o.cy = sum[WIDTH];
      end
    endcase
    // Flags come from the ALU result before the shifter.
    o.n = r[WIDTH-1];
    o.z = (r == '0);
    case (s)
      2'b10:   o.res = {r[WIDTH-9:0], 8'h00};
      2'b01:   o.res = {r[WIDTH-1], r[WIDTH-1:1]};
      2'b11:   begin
        o.res = r;
        o.err = 1'b1;
      end
      default: o.res = r;
    endcase
    return o;
  endfunction

  logic vld_out;
  res_t res_out;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic             vld_p1;
      logic             vld_p2;
      logic [5:0]       ctrl_p1;
      logic [1:0]       shift_p1;
      logic [WIDTH-1:0] a_p1;
      logic [WIDTH-1:0] b_p1;
      res_t             res_p2;
      logic             adv_p2;

      // Result stage can load when empty or when its op leaves this cycle.
      assign adv_p2   = !vld_p2 || out_ready;
      assign in_ready = !vld_p1 || adv_p2;

      // Valid bits of both stages; reset discards everything in flight.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1 <= 1'b0;
          vld_p2 <= 1'b0;
        end else begin
          if (in_ready) vld_p1 <= in_valid;
          if (adv_p2)   vld_p2 <= vld_p1;
        end
      end

      // ---- stage 1: operand register ----
      always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
          ctrl_p1  <= ctrl;
          shift_p1 <= shift;
          a_p1     <= A;
          b_p1     <= B;
        end
      end

      // ---- stage 2: result register, held while stalled ----
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_p2 <= '0;
        end else if (adv_p2 && vld_p1) begin
          res_p2 <= alu(ctrl_p1, shift_p1, a_p1, b_p1);
        end
      end

      assign vld_out = vld_p2;
      assign res_out = res_p2;
    end else begin : g_pipe1
      logic vld_p1;
      res_t res_p1;

      assign in_ready = !vld_p1 || out_ready;

      // Single valid bit; reset discards the op in flight.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_p1 <= 1'b0;
        end else if (in_ready) begin
          vld_p1 <= in_valid;
        end
      end

      // ---- stage 1: result register, held while stalled ----
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          res_p1 <= '0;
        end else if (in_valid && in_ready) begin
          res_p1 <= alu(ctrl, shift, A, B);
        end
      end

      assign vld_out = vld_p1;
      assign res_out = res_p1;
    end
  endgenerate

  assign out_valid = vld_out;
  assign out       = res_out.res;
  assign carryout  = res_out.cy;
  assign N         = res_out.n;
  assign Z         = res_out.z;
  assign shift_err = res_out.err;

  // Flag register captures {N,Z} only when a result is handed off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nz_q <= 2'b00;
    end else if (out_valid && out_ready) begin
      nz_q <= {N, Z};
    end
  end

endmodule

// File: tb/tb_ula_pipe_param.sv
// Bench for ula_pipe_param: directed spec cases, back-pressure, reset in flight,
// randomized traffic against a scoreboard model, and a WIDTH=16/PIPE=1 instance.
module tb_ula_pipe_param;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [5:0]    ctrl;
  logic [1:0]    shift;
  logic [W-1:0]  A, B, out;
  logic          carryout, N, Z, shift_err;
  logic [1:0]    nz_q;

  logic          in_valid16, in_ready16, out_valid16, out_ready16;
  logic [5:0]    ctrl16;
  logic [1:0]    shift16;
  logic [15:0]   a16, b16, out16;
  logic          carryout16, n16, z16, shift_err16;
  logic [1:0]    nz_q16;

  ula_pipe_param #(.WIDTH(W), .PIPE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .shift(shift), .A(A), .B(B), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .carryout(carryout), .N(N), .Z(Z),
    .shift_err(shift_err), .nz_q(nz_q));

  ula_pipe_param #(.WIDTH(16), .PIPE(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .ctrl(ctrl16), .shift(shift16), .A(a16), .B(b16), .out_valid(out_valid16),
    .out_ready(out_ready16), .out(out16), .carryout(carryout16), .N(n16), .Z(z16),
    .shift_err(shift_err16), .nz_q(nz_q16));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] o;
    logic        cy, n, z, err;
  } exp_t;

  exp_t       q[$];
  logic [1:0] nz_exp;

  localparam logic [31:0] AV = 32'hAAAAFAB2;
  localparam logic [31:0] BV = 32'hBBBB13AB;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: operand gating, function, flags, shifter in plain arithmetic.
  function automatic exp_t ref_op(input int w, input logic [5:0] c, input logic [1:0] s,
                                  input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] mask, a, b, r, full;
    exp_t e;
    mask = (64'd1 << w) - 64'd1;
    a = c[3] ? (ai & mask) : 64'd0;
    if (c[1]) a = ~a & mask;
    b = c[2] ? (bi & mask) : 64'd0;
    e.cy = 1'b0;
    full = 64'd0;
    case (c[5:4])
      2'd0: r = a & b;
      2'd1: r = a | b;
      2'd2: r = ~b & mask;
      default: begin
        full = a + b + 64'(c[0]);
        r    = full & mask;
        e.cy = full[w];
      end
    endcase
    e.n   = r[w-1];
    e.z   = (r == 64'd0);
    e.err = (s == 2'b11);
    case (s)
      2'b10:   e.o = (r << 8) & mask;
      2'b01:   e.o = (r >> 1) | (e.n ? (64'd1 << (w - 1)) : 64'd0);
      default: e.o = r;
    endcase
    return e;
  endfunction

  // One clock of the 32-bit DUT: drive, settle, score handshakes, clock, check nz_q.
  task automatic cyc(input logic v, input logic [5:0] c, input logic [1:0] s,
                     input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy,
                     output logic acc);
    exp_t e;
    logic rst_cyc;
    in_valid = v; ctrl = c; shift = s; A = a; B = b; out_ready = ordy;
    #1;
    rst_cyc = !rst_n;
    acc = in_valid && in_ready && rst_n;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 64'(out_valid), 0);
        end else begin
          e = q.pop_front();
          chk("sb_out", 64'(out), e.o);
          chk("sb_carry", 64'(carryout), 64'(e.cy));
          chk("sb_nz", 64'({N, Z}), 64'({e.n, e.z}));
          chk("sb_err", 64'(shift_err), 64'(e.err));
          nz_exp = {e.n, e.z};
        end
      end
      if (acc) q.push_back(ref_op(W, c, s, 64'(a), 64'(b)));
    end
    @(posedge clk);
    #1;
    if (rst_cyc) begin
      q.delete();
      nz_exp = 2'b00;
    end
    chk("nz_q", 64'(nz_q), 64'(nz_exp));
  endtask

  task automatic idle();
    logic acc;
    cyc(1'b0, 6'd0, 2'd0, '0, '0, 1'b1, acc);
  endtask

  // Single op on AV/BV with constant expectations and 2-cycle latency check.
  task automatic dir_op(input string tag, input logic [5:0] c, input logic [1:0] s,
                        input logic [31:0] eo, input logic ecy, input logic en,
                        input logic ez, input logic eerr);
    logic acc;
    cyc(1'b1, c, s, AV, BV, 1'b1, acc);
    chk({tag, "_acc"}, 64'(acc), 1);
    chk({tag, "_lat1_valid"}, 64'(out_valid), 0);
    cyc(1'b0, 6'd0, 2'd0, '0, '0, 1'b1, acc);
    chk({tag, "_lat2_valid"}, 64'(out_valid), 1);
    chk({tag, "_out"}, 64'(out), 64'(eo));
    chk({tag, "_carry"}, 64'(carryout), 64'(ecy));
    chk({tag, "_N"}, 64'(N), 64'(en));
    chk({tag, "_Z"}, 64'(Z), 64'(ez));
    chk({tag, "_shift_err"}, 64'(shift_err), 64'(eerr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] hold;
    logic [31:0] corner [4];
    exp_t        ex, ey;

    corner[0] = 32'h0; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h80000000; corner[3] = 32'h7FFFFFFF;
    nz_exp = 2'b00;
    in_valid16 = 1'b0; ctrl16 = '0; shift16 = '0; a16 = '0; b16 = '0; out_ready16 = 1'b1;

    // Reset
    rst_n = 1'b0;
    cyc(1'b1, 6'b111100, 2'b00, AV, BV, 1'b1, acc);
    cyc(1'b1, 6'b111100, 2'b00, AV, BV, 1'b1, acc);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out", 64'(out), 0);
    chk("rst_carry", 64'(carryout), 0);
    chk("rst_NZ", 64'({N, Z}), 0);
    chk("rst_shift_err", 64'(shift_err), 0);
    chk("rst_nz_q", 64'(nz_q), 0);
    chk("rst16_out_valid", 64'(out_valid16), 0);

    // Directed function and shifter cases
    dir_op("t1_add",     6'b111100, 2'b00, 32'h66660E5D, 1'b1, 1'b0, 1'b0, 1'b0);
    dir_op("t2_sub_inc", 6'b111111, 2'b00, 32'h111018F9, 1'b1, 1'b0, 1'b0, 1'b0);
    dir_op("t2_neg_a",   6'b111011, 2'b00, 32'h5555054E, 1'b0, 1'b0, 1'b0, 1'b0);
    dir_op("t2_zero",    6'b010000, 2'b00, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0);
    dir_op("t2_ones",    6'b110010, 2'b00, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    dir_op("t3_sll8",    6'b011000, 2'b10, 32'hAAFAB200, 1'b0, 1'b1, 1'b0, 1'b0);
    dir_op("t3_sra1",    6'b010100, 2'b01, 32'hDDDD89D5, 1'b0, 1'b1, 1'b0, 1'b0);
    dir_op("t3_bad",     6'b011000, 2'b11, 32'hAAAAFAB2, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();

    // Back-pressure: two accepts then stall, results drain in order
    cyc(1'b1, 6'b111100, 2'b00, AV, BV, 1'b0, acc);
    chk("bp_acc1", 64'(acc), 1);
    cyc(1'b1, 6'b110010, 2'b00, AV, BV, 1'b0, acc);
    chk("bp_acc2", 64'(acc), 1);
    cyc(1'b1, 6'b010000, 2'b00, AV, BV, 1'b0, acc);
    chk("bp_acc3_blocked", 64'(acc), 0);
    chk("bp_in_ready", 64'(in_ready), 0);
    chk("bp_valid_held", 64'(out_valid), 1);
    hold = out;
    cyc(1'b1, 6'b010000, 2'b00, AV, BV, 1'b0, acc);
    chk("bp_acc3_still_blocked", 64'(acc), 0);
    chk("bp_out_stable", 64'(out), 64'(hold));
    chk("bp_out_first", 64'(out), 'h66660E5D);
    cyc(1'b1, 6'b010000, 2'b00, AV, BV, 1'b1, acc);
    chk("bp_acc3_with_drain", 64'(acc), 1);
    idle();
    idle();
    idle();
    chk("bp_nz_last", 64'(nz_q), 'b01);
    chk("bp_queue_empty", 64'(q.size()), 0);

    // Reset with two ops in flight
    cyc(1'b1, 6'b110010, 2'b00, AV, BV, 1'b1, acc);
    cyc(1'b1, 6'b111100, 2'b00, AV, BV, 1'b1, acc);
    rst_n = 1'b0;
    cyc(1'b1, 6'b111111, 2'b00, AV, BV, 1'b1, acc);
    rst_n = 1'b1;
    chk("t5_out_valid", 64'(out_valid), 0);
    chk("t5_nz_q", 64'(nz_q), 0);
    chk("t5_in_ready", 64'(in_ready), 1);
    chk("t5_out", 64'(out), 0);
    dir_op("t5_after", 6'b111100, 2'b00, 32'h66660E5D, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      cyc(1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom_range(0, 3)), ra, rb,
          1'($urandom_range(0, 3) != 0), acc);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) idle();
    chk("drain_empty", 64'(q.size()), 0);

    // WIDTH=16, PIPE=1 instance
    in_valid16 = 1'b1; ctrl16 = 6'b111100; shift16 = 2'b00; a16 = 16'hFFFF; b16 = 16'h0001;
    out_ready16 = 1'b1;
    #1;
    chk("t6_in_ready", 64'(in_ready16), 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("t6_lat1_valid", 64'(out_valid16), 1);
    chk("t6_out", 64'(out16), 0);
    chk("t6_carry", 64'(carryout16), 1);
    chk("t6_Z", 64'(z16), 1);
    chk("t6_N", 64'(n16), 0);
    @(posedge clk); #1;
    chk("t6_nz_q", 64'(nz_q16), 'b01);
    chk("t6_drained", 64'(out_valid16), 0);

    ex = ref_op(16, 6'b010100, 2'b01, 64'h0, 64'h8642);
    ey = ref_op(16, 6'b011000, 2'b10, 64'h1234, 64'h0);
    in_valid16 = 1'b1; ctrl16 = 6'b010100; shift16 = 2'b01; a16 = 16'h0000; b16 = 16'h8642;
    out_ready16 = 1'b0;
    @(posedge clk); #1;
    ctrl16 = 6'b011000; shift16 = 2'b10; a16 = 16'h1234; b16 = 16'h0000;
    #1;
    chk("t6_bp_in_ready", 64'(in_ready16), 0);
    chk("t6_bp_out", 64'(out16), ex.o);
    @(posedge clk); #1;
    chk("t6_bp_out_stable", 64'(out16), ex.o);
    chk("t6_bp_nz_hold", 64'(nz_q16), 'b01);
    out_ready16 = 1'b1;
    #1;
    chk("t6_in_ready_release", 64'(in_ready16), 1);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    chk("t6_nz_after_x", 64'(nz_q16), 64'({ex.n, ex.z}));
    chk("t6_out_y", 64'(out16), ey.o);
    chk("t6_valid_y", 64'(out_valid16), 1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
